auth_entry: RTL and testbench
=============================

# auth_entry

Sequential code-entry controller for the auth lock datapath. Collects a setter code and guess codes one bit at a time, holds them on parallel buses for the combinational code comparator, and drives the comparator's submit strobe. It then consumes the comparator's matched/unmatched verdict to unlock, count failed attempts, and enforce a timed lockout.

## Interface
- CODE_W, 4: code length in bits.
- MAX_TRIES, 3: failed guesses allowed before lockout (≥1).
- LOCKOUT_CYCLES, 16: clock cycles spent in lockout (≥2).

- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- bit_valid  in  1  bit_in is valid this cycle.
- bit_in  in  1  serial code bit, MSB first.
- submit  in  1  one-cycle button press.
- mode_set  in  1  qualifies submit in OPEN as a request to re-enroll.
- matched  in  1  comparator verdict: codes equal, gated by check.
- unmatched  in  1  comparator verdict: codes differ, gated by check.
- s_code  out  CODE_W  enrolled setter code to comparator.
- g_code  out  CODE_W  current guess to comparator.
- check  out  1  comparator submit strobe, one-cycle pulse.
- enrolling  out  1  state is ENROLL.
- unlocked  out  1  state is OPEN.
- locked_out  out  1  state is LOCK.
- tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts.

## Operation
- States: ENROLL, ENTRY, CHECK, OPEN, LOCK. Internal bit_cnt saturates at CODE_W.
- ENROLL: each bit_valid shifts code <= {code[CODE_W-2:0], bit_in} into s_code. On the CODE_W-th bit, go to ENTRY and clear bit_cnt and g_code. submit is ignored.
- ENTRY: bit_valid shifts into g_code while bit_cnt < CODE_W. Bits beyond CODE_W are dropped and g_code is held.
  - submit with bit_cnt == CODE_W moves to CHECK.
  - submit with bit_cnt < CODE_W is ignored.
  - If bit_valid and submit arrive in the same cycle, the bit is processed and submit is ignored.
- CHECK (exactly one cycle): check = 1. matched and unmatched are sampled in this cycle.
  - matched=1 and unmatched=0: go to OPEN and set tries_left = MAX_TRIES.
  - Any other combination (unmatched, both high, or neither high) is a failure:
    - decrement tries_left;
    - if the result is 0, go to LOCK;
    - otherwise go to ENTRY.
  - Both exits clear g_code and bit_cnt.
- OPEN: unlocked = 1. bit_valid is ignored.
  - submit with mode_set=1 goes to ENROLL and clears s_code and bit_cnt.
  - submit with mode_set=0 relocks to ENTRY.
- LOCK: locked_out = 1 and all inputs are ignored. A counter runs LOCKOUT_CYCLES cycles, then the block goes to ENTRY with tries_left = MAX_TRIES.
- s_code is never modified outside ENROLL.

## Timing
- Reset values: state=ENROLL, s_code=0, g_code=0, check=0, enrolling=1, unlocked=0, locked_out=0, tries_left=MAX_TRIES, bit_cnt=0, lockout counter=0.
- Reset has priority over every input. Asserting rst mid-operation (including in CHECK or LOCK) returns all values above on the next edge and discards the enrolled code.
- All outputs are registered or decoded from registered state. No combinational input-to-output path exists.
- Bit accepted at edge N → visible on s_code/g_code after edge N.
- Accepted submit at edge N → check high for cycle N+1 → unlocked or locked_out high from edge N+2.
- LOCK occupies exactly LOCKOUT_CYCLES cycles: locked_out is high from edge N+2 through edge N+1+LOCKOUT_CYCLES.
- check is never high for two consecutive cycles.

## Structure
- Shared package auth_pkg holds:
  - the state enum (auth_state_t);
  - the CODE_W default;
  - the verdict-decode constants used by the comparator and auth_entry.
- Sub-module auth_bit_collector: CODE_W shift register plus saturating bit_cnt, with clear and enable inputs. It is instantiated twice, once for s_code and once for g_code.
- The FSM, tries counter and lockout counter live in auth_entry.

## Test plan
All scenarios use CODE_W=4, MAX_TRIES=3, LOCKOUT_CYCLES=16.
- Enroll and open: shift 1,0,1,1 → s_code=4'b1011 and enrolling=0. Shift 1,0,1,1, then submit → check pulses one cycle; with matched=1, unlocked=1 two cycles after submit and tries_left=3.
- Short guess: in ENTRY, 3 bits then submit → no check and state unchanged. A 4th bit, then submit → check.
- Lockout: three submits each answered unmatched=1 → tries_left goes 2,1,0. locked_out=1 for exactly 16 cycles, then ENTRY with tries_left=3. bit_valid/submit during LOCK have no effect.
- Verdict fault: matched=1 and unmatched=1 together during check → treated as failure, tries_left decremented, unlocked stays 0.
- Same-cycle events: bit_valid and submit together with bit_cnt=4 → submit ignored and no check. Six bits 1,1,0,0,1,0 → g_code=4'b1100.
- Reset and re-enroll: rst asserted in CHECK → all outputs at reset values on the next edge. In OPEN, submit with mode_set=1 → enrolling=1 and s_code=0.

Source files
------------

// File: rtl/auth_pkg.sv
// Shared types and constants for the auth lock datapath: FSM state encoding,
// default code width and the comparator verdict decode.
package auth_pkg;

  typedef enum logic [2:0] {
    ST_ENROLL,
    ST_ENTRY,
    ST_CHECK,
    ST_OPEN,
    ST_LOCK
  } auth_state_t;

  localparam int AUTH_CODE_W = 4;

  // Verdict bus is {matched, unmatched}; only a clean match counts as a pass.
  localparam logic [1:0] VERDICT_MATCH = 2'b10;

  function automatic logic verdict_pass(input logic matched, input logic unmatched);
    return {matched, unmatched} == VERDICT_MATCH;
  endfunction

endpackage

// File: rtl/auth_bit_collector.sv
// MSB-first serial-to-parallel shift register with a saturating bit count.
// Once W bits are held, further enabled bits are dropped and the code is frozen.
module auth_bit_collector #(
  parameter  int W  = 4,
  localparam int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  input  logic          bit_in,
  output logic [W-1:0]  code,
  output logic [CW-1:0] cnt
);

  logic full;
  assign full = (cnt == CW'(W));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      code <= '0;
      cnt  <= '0;
    end else if (en && !full) begin
      code <= {code[W-2:0], bit_in};
      cnt  <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/auth_entry.sv
// Code-entry controller: enrolls a setter code, collects guesses, strobes the
// comparator and acts on its verdict (unlock, count failures, timed lockout).
module auth_entry
  import auth_pkg::*;
#(
  parameter  int CODE_W         = AUTH_CODE_W,
  parameter  int MAX_TRIES      = 3,
  parameter  int LOCKOUT_CYCLES = 16,
  localparam int TW             = $clog2(MAX_TRIES + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              submit,
  input  logic              mode_set,
  input  logic              matched,
  input  logic              unmatched,
  output logic [CODE_W-1:0] s_code,
  output logic [CODE_W-1:0] g_code,
  output logic              check,
  output logic              enrolling,
  output logic              unlocked,
  output logic              locked_out,
  output logic [TW-1:0]     tries_left
);

  localparam int CW = $clog2(CODE_W + 1);
  localparam int LW = $clog2(LOCKOUT_CYCLES);

  auth_state_t state, state_nx;
  logic [TW-1:0] tries_nx;
  logic [LW-1:0] lock_cnt, lock_nx;
  logic [CW-1:0] s_cnt, g_cnt;
  logic          s_en, s_clr, g_en, g_clr;

  auth_bit_collector #(.W(CODE_W)) u_setter (
    .clk(clk), .rst(rst), .clr(s_clr), .en(s_en), .bit_in(bit_in),
    .code(s_code), .cnt(s_cnt)
  );

  auth_bit_collector #(.W(CODE_W)) u_guess (
    .clk(clk), .rst(rst), .clr(g_clr), .en(g_en), .bit_in(bit_in),
    .code(g_code), .cnt(g_cnt)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_ENROLL;
      tries_left <= TW'(MAX_TRIES);
      lock_cnt   <= '0;
    end else begin
      state      <= state_nx;
      tries_left <= tries_nx;
      lock_cnt   <= lock_nx;
    end
  end

  // bit_valid qualifies bit_in for one cycle; submit is a one-cycle press that
  // only takes effect when no bit is offered in the same cycle.
  always_comb begin
    state_nx = state;
    tries_nx = tries_left;
    lock_nx  = lock_cnt;
    s_en     = 1'b0;
    s_clr    = 1'b0;
    g_en     = 1'b0;
    g_clr    = 1'b0;
    case (state)
      ST_ENROLL: begin
        s_en = bit_valid;
        if (bit_valid && s_cnt == CW'(CODE_W - 1)) begin
          state_nx = ST_ENTRY;
          g_clr    = 1'b1;
        end
      end
      ST_ENTRY: begin
        g_en = bit_valid;
        if (submit && !bit_valid && g_cnt == CW'(CODE_W)) state_nx = ST_CHECK;
      end
      ST_CHECK: begin
        g_clr = 1'b1;
        if (verdict_pass(matched, unmatched)) begin
          state_nx = ST_OPEN;
          tries_nx = TW'(MAX_TRIES);
        end else begin
          tries_nx = tries_left - 1'b1;
          lock_nx  = '0;
          state_nx = (tries_left == TW'(1)) ? ST_LOCK : ST_ENTRY;
        end
      end
      ST_OPEN: begin
        if (submit) begin
          if (mode_set) begin
            state_nx = ST_ENROLL;
            s_clr    = 1'b1;
          end else begin
            state_nx = ST_ENTRY;
          end
        end
      end
      ST_LOCK: begin
        if (lock_cnt == LW'(LOCKOUT_CYCLES - 1)) begin
          state_nx = ST_ENTRY;
          tries_nx = TW'(MAX_TRIES);
          lock_nx  = '0;
        end else begin
          lock_nx = lock_cnt + 1'b1;
        end
      end
      default: state_nx = ST_ENROLL;
    endcase
  end

  assign check      = (state == ST_CHECK);
  assign enrolling  = (state == ST_ENROLL);
  assign unlocked   = (state == ST_OPEN);
  assign locked_out = (state == ST_LOCK);

endmodule

// File: tb/tb_auth_entry.sv
// Bench for auth_entry: directed walk through the main scenarios followed by
// randomized traffic, all scored cycle-by-cycle against a behavioural model.
module tb_auth_entry;

  localparam int CODE_W         = 4;
  localparam int MAX_TRIES      = 3;
  localparam int LOCKOUT_CYCLES = 16;
  localparam int TW             = 2;
  localparam int EW             = 2 * CODE_W + 4 + TW;

  logic clk = 1'b0;
  logic rst, bit_valid, bit_in, submit, mode_set, matched, unmatched;
  logic [CODE_W-1:0] s_code, g_code;
  logic check, enrolling, unlocked, locked_out;
  logic [TW-1:0] tries_left;

  auth_entry #(
    .CODE_W(CODE_W), .MAX_TRIES(MAX_TRIES), .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
  ) dut (
    .clk(clk), .rst(rst), .bit_valid(bit_valid), .bit_in(bit_in),
    .submit(submit), .mode_set(mode_set), .matched(matched), .unmatched(unmatched),
    .s_code(s_code), .g_code(g_code), .check(check), .enrolling(enrolling),
    .unlocked(unlocked), .locked_out(locked_out), .tries_left(tries_left)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef enum int {M_ENROLL, M_ENTRY, M_CHECK, M_OPEN, M_LOCK} mode_e;

  mode_e m_mode;
  int    m_s, m_s_n, m_g, m_g_n, m_tries, m_lock_left;

  function automatic logic [EW-1:0] model_out();
    return {CODE_W'(m_s), CODE_W'(m_g), m_mode == M_CHECK, m_mode == M_ENROLL,
            m_mode == M_OPEN, m_mode == M_LOCK, TW'(m_tries)};
  endfunction

  function automatic void model_reset();
    m_mode      = M_ENROLL;
    m_s         = 0;
    m_s_n       = 0;
    m_g         = 0;
    m_g_n       = 0;
    m_tries     = MAX_TRIES;
    m_lock_left = 0;
  endfunction

  function automatic void model_step(input logic r, input logic bv, input logic bi,
                                     input logic sb, input logic ms,
                                     input logic mt, input logic um);
    if (r) begin
      model_reset();
      return;
    end
    case (m_mode)
      M_ENROLL: if (bv) begin
        m_s   = (m_s * 2 + int'(bi)) % (1 << CODE_W);
        m_s_n = m_s_n + 1;
        if (m_s_n == CODE_W) begin
          m_mode = M_ENTRY;
          m_g    = 0;
          m_g_n  = 0;
        end
      end
      M_ENTRY: begin
        if (bv) begin
          if (m_g_n < CODE_W) begin
            m_g   = (m_g * 2 + int'(bi)) % (1 << CODE_W);
            m_g_n = m_g_n + 1;
          end
        end else if (sb && m_g_n == CODE_W) begin
          m_mode = M_CHECK;
        end
      end
      M_CHECK: begin
        m_g   = 0;
        m_g_n = 0;
        if (mt && !um) begin
          m_mode  = M_OPEN;
          m_tries = MAX_TRIES;
        end else begin
          m_tries = m_tries - 1;
          if (m_tries == 0) begin
            m_mode      = M_LOCK;
            m_lock_left = LOCKOUT_CYCLES;
          end else begin
            m_mode = M_ENTRY;
          end
        end
      end
      M_OPEN: if (sb) begin
        if (ms) begin
          m_mode = M_ENROLL;
          m_s    = 0;
          m_s_n  = 0;
        end else begin
          m_mode = M_ENTRY;
        end
      end
      M_LOCK: begin
        m_lock_left = m_lock_left - 1;
        if (m_lock_left == 0) begin
          m_mode  = M_ENTRY;
          m_tries = MAX_TRIES;
        end
      end
      default: ;
    endcase
  endfunction

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] act_v, exp_v;
  int  n_cmp = 0;
  int  n_bad = 0;
  bit  mon_en = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      act_v = {s_code, g_code, check, enrolling, unlocked, locked_out, tries_left};
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL exp_underflow t=%0t actual=%b required=<queued entry>", $time, act_v);
      end else begin
        exp_v = exp_q.pop_front();
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL outputs t=%0t {s,g,chk,enr,unl,lck,tries} actual=%b required=%b",
                   $time, act_v, exp_v);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic r, input logic bv, input logic bi, input logic sb,
                       input logic ms, input logic mt, input logic um);
    rst = r; bit_valid = bv; bit_in = bi; submit = sb;
    mode_set = ms; matched = mt; unmatched = um;
    model_step(r, bv, bi, sb, ms, mt, um);
    exp_q.push_back(model_out());
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    drive(1'b0, 1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic press(input logic ms);
    drive(1'b0, 1'b0, 1'b0, 1'b1, ms, 1'b0, 1'b0);
  endtask

  task automatic verdict(input logic mt, input logic um);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, mt, um);
  endtask

  task automatic send_code(input logic [CODE_W-1:0] c);
    logic [CODE_W-1:0] cv;
    cv = c;
    for (int i = CODE_W - 1; i >= 0; i--) send_bit(cv[i]);
  endtask

  task automatic rand_cycle();
    logic r, bv, bi, sb, ms, mt, um;
    r  = ($urandom_range(0, 199) == 0);
    bv = ($urandom_range(0, 9) < 6);
    bi = 1'($urandom_range(0, 1));
    // Bias guesses toward the enrolled code so OPEN is reached regularly.
    if (m_mode == M_ENTRY && m_g_n < CODE_W && $urandom_range(0, 9) < 8)
      bi = 1'((m_s >> (CODE_W - 1 - m_g_n)) & 1);
    sb = ($urandom_range(0, 9) < 3);
    ms = 1'($urandom_range(0, 1));
    if (m_mode == M_CHECK && $urandom_range(0, 3) != 0) begin
      mt = (m_g == m_s);
      um = !mt;
    end else begin
      mt = 1'($urandom_range(0, 1));
      um = 1'($urandom_range(0, 1));
    end
    drive(r, bv, bi, sb, ms, mt, um);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; bit_valid = 1'b0; bit_in = 1'b0; submit = 1'b0;
    mode_set = 1'b0; matched = 1'b0; unmatched = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    exp_q.push_back(model_out());
    mon_en = 1'b1;

    // Enroll 1011, guess it, clean match -> OPEN
    send_code(4'b1011);
    send_code(4'b1011);
    press(1'b0);
    verdict(1'b1, 1'b0);
    idle();
    idle();
    press(1'b0);

    // Short guess ignored, then a full one answered unmatched
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    press(1'b0);
    idle();
    send_bit(1'b0);
    press(1'b0);
    verdict(1'b0, 1'b1);

    // Faulty verdict (both high), then no verdict at all -> LOCK
    send_code(4'b1011);
    press(1'b0);
    verdict(1'b1, 1'b1);
    send_code(4'b0000);
    press(1'b0);
    verdict(1'b0, 1'b0);
    for (int i = 0; i < LOCKOUT_CYCLES; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle();

    // Bit and submit together with a full guess; extra bits dropped
    send_code(4'b1100);
    drive(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    idle();
    press(1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();

    // Re-enroll from OPEN
    send_code(4'b0110);
    send_code(4'b0110);
    press(1'b0);
    verdict(1'b1, 1'b0);
    press(1'b1);
    idle();

    for (int i = 0; i < 3000; i++) rand_cycle();

    @(negedge clk);
    #1;
    mon_en = 1'b0;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL exp_leftover actual=%0d entries required=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
